// File: rtl/doc_hw_mbox_pkg.sv
// doc_hw_mbox_pkg: SDM mailbox response header layout, sensor command codes and parser states
package doc_hw_mbox_pkg;
  localparam int ID_LSB  = 24;
  localparam int ID_MSB  = 27;
  localparam int LEN_LSB = 12;
  localparam int LEN_MSB = 22;
  localparam int ERR_LSB = 0;
  localparam int ERR_MSB = 10;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
  localparam int ERR_W   = ERR_MSB - ERR_LSB + 1;
  localparam logic [10:0] CMD_GET_VOLTAGE     = 11'h018;
  localparam logic [10:0] CMD_GET_TEMPERATURE = 11'h019;
  typedef enum logic [1:0] {IDLE, DATA, DRAIN} rsp_state_e;
endpackage

// File: rtl/mbox_result_bank.sv
// mbox_result_bank: per-ID result words, valid/err bitmaps with commit-over-clear priority, registered read port
module mbox_result_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [ID_WIDTH-1:0]      wid_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     werr_i,
  input  logic                     clear_i,
  input  logic [ID_WIDTH-1:0]      rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic [2**ID_WIDTH-1:0]   slot_valid_o,
  output logic [2**ID_WIDTH-1:0]   slot_err_o
);
  logic [DATA_WIDTH-1:0] mem [2**ID_WIDTH];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem          <= '{default: '0};
      rd_data_o    <= '0;
      slot_valid_o <= '0;
      slot_err_o   <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
      if (clear_i) begin
        slot_valid_o <= '0;
        slot_err_o   <= '0;
      end
      if (we_i) begin
        mem[wid_i]          <= wdata_i;
        slot_valid_o[wid_i] <= 1'b1;
        slot_err_o[wid_i]   <= werr_i;
      end
    end
  end
endmodule

// File: rtl/mbox_response_parser.sv
// mbox_response_parser: parses SDM mailbox sensor responses into a per-ID result bank
// Define DOC_RSP_TIMEOUT_EN to add the inter-beat watchdog and its timeout_o pulse.
module mbox_response_parser
  import doc_hw_mbox_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int ERRCNT_WIDTH   = 8
`ifdef DOC_RSP_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rsp_valid_i,
  output logic                     rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]    rsp_data_i,
  input  logic                     rsp_sop_i,
  input  logic                     rsp_eop_i,
  input  logic                     clear_i,
  input  logic [ID_WIDTH-1:0]      rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic [2**ID_WIDTH-1:0]   slot_valid_o,
  output logic [2**ID_WIDTH-1:0]   slot_err_o,
`ifdef DOC_RSP_TIMEOUT_EN
  output logic                     timeout_o,
`endif
  output logic                     upd_o,
  output logic [ID_WIDTH-1:0]      upd_id_o,
  output logic [DATA_WIDTH-1:0]    upd_data_o,
  output logic [ERRCNT_WIDTH-1:0]  proto_err_cnt_o
);
  rsp_state_e state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d, cid, hid;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d, hlen;
  logic [ERR_W-1:0] err_q, err_d, herr;
  logic [DATA_WIDTH-1:0] data_q, data_d, cdata;
  logic acc, commit, cerr;
  logic [1:0] inc;
  logic [ERRCNT_WIDTH:0] err_sum;
  assign acc     = rsp_valid_i & rsp_ready_o;
  assign hid     = rsp_data_i[ID_LSB +: ID_WIDTH];
  assign hlen    = rsp_data_i[LEN_MSB:LEN_LSB];
  assign herr    = rsp_data_i[ERR_MSB:ERR_LSB];
  assign err_sum = {1'b0, proto_err_cnt_o} + {{(ERRCNT_WIDTH-1){1'b0}}, inc};
`ifdef DOC_RSP_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic wd_hit;
  assign wd_hit = (state_q != IDLE) && !acc && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd_q      <= (state_q == IDLE || acc || wd_hit) ? '0 : wd_q + 1'b1;
      timeout_o <= wd_hit;
    end
  end
`endif
  // A sop beat always restarts header parsing, whatever state it interrupts.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    err_d   = err_q;
    rem_d   = rem_q;
    data_d  = data_q;
    commit  = 1'b0;
    cid     = id_q;
    cdata   = data_q;
    cerr    = err_q != '0;
    inc     = 2'd0;
    if (acc) begin
      if (rsp_sop_i) begin
        inc   = {1'b0, state_q != IDLE};
        id_d  = hid;
        len_d = hlen;
        err_d = herr;
        rem_d = hlen;
        state_d = rsp_eop_i ? IDLE : DATA;
        if (rsp_eop_i && hlen == '0 && herr != '0) begin
          commit = 1'b1;
          cid    = hid;
          cdata  = '0;
          cerr   = 1'b1;
        end else if (rsp_eop_i) begin
          inc = inc + 2'd1;
        end
      end else if (state_q == IDLE) begin
        inc     = 2'd1;
        state_d = rsp_eop_i ? IDLE : DRAIN;
      end else if (state_q == DATA) begin
        rem_d  = rem_q - 1'b1;
        data_d = (rem_q == len_q) ? rsp_data_i : data_q;
        cdata  = data_d;
        commit = rsp_eop_i && rem_q == 1;
        inc    = {1'b0, rsp_eop_i ? rem_q != 1 : rem_q <= 1};
        state_d = rsp_eop_i ? IDLE : (rem_q <= 1 ? DRAIN : DATA);
      end else begin
        state_d = rsp_eop_i ? IDLE : DRAIN;
      end
    end
`ifdef DOC_RSP_TIMEOUT_EN
    else if (wd_hit) begin
      state_d = IDLE;
      inc     = 2'd1;
    end
`endif
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      id_q            <= '0;
      len_q           <= '0;
      err_q           <= '0;
      rem_q           <= '0;
      data_q          <= '0;
      rsp_ready_o     <= 1'b0;
      upd_o           <= 1'b0;
      upd_id_o        <= '0;
      upd_data_o      <= '0;
      proto_err_cnt_o <= '0;
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      len_q           <= len_d;
      err_q           <= err_d;
      rem_q           <= rem_d;
      data_q          <= data_d;
      rsp_ready_o     <= 1'b1;
      upd_o           <= commit;
      upd_id_o        <= commit ? cid : upd_id_o;
      upd_data_o      <= commit ? cdata : upd_data_o;
      proto_err_cnt_o <= err_sum[ERRCNT_WIDTH] ? '1 : err_sum[ERRCNT_WIDTH-1:0];
    end
  end
  mbox_result_bank #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) u_bank (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .we_i        (commit),
    .wid_i       (cid),
    .wdata_i     (cdata),
    .werr_i      (cerr),
    .clear_i     (clear_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .slot_valid_o(slot_valid_o),
    .slot_err_o  (slot_err_o)
  );
endmodule

// File: tb/tb_mbox_response_parser.sv
// tb_mbox_response_parser: table-driven packets with an update scoreboard, plus hand-written corner sequences
module tb_mbox_response_parser;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic rsp_valid_i = 1'b0, rsp_sop_i = 1'b0, rsp_eop_i = 1'b0, clear_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic [3:0] rd_addr_i = '0;
  logic rsp_ready_o, upd_o;
  logic [31:0] rd_data_o, upd_data_o;
  logic [15:0] slot_valid_o, slot_err_o;
  logic [3:0] upd_id_o;
  logic [7:0] proto_err_cnt_o;
`ifdef DOC_RSP_TIMEOUT_EN
  logic timeout_o;
`endif
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] id; logic [31:0] data;} upd_t;
  upd_t sb[$];
  upd_t exp_u;
  typedef struct {
    int n; logic [2:0][31:0] d; logic [2:0] sop, eop;
    logic commit; logic [3:0] id; logic [31:0] data; logic err; int inc;
  } vec_t;
  vec_t vt[10];
  logic [15:0] m_valid = '0, m_err = '0;
  logic [31:0] m_bank [16];
  int m_cnt = 0;

  mbox_response_parser dut (
    .clk_i(clk_i), .rst_i(rst_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_data_i(rsp_data_i), .rsp_sop_i(rsp_sop_i), .rsp_eop_i(rsp_eop_i), .clear_i(clear_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .slot_valid_o(slot_valid_o), .slot_err_o(slot_err_o),
`ifdef DOC_RSP_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .upd_o(upd_o), .upd_id_o(upd_id_o), .upd_data_o(upd_data_o), .proto_err_cnt_o(proto_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic e);
    rsp_valid_i = 1'b1; rsp_data_i = d; rsp_sop_i = s; rsp_eop_i = e;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    rsp_valid_i = 1'b0; rsp_sop_i = 1'b0; rsp_eop_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] data);
    upd_t u;
    u.id = id; u.data = data;
    sb.push_back(u);
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] d0, d1, d2, input logic [2:0] sop, eop,
                              input logic commit, input logic [3:0] id, input logic [31:0] data,
                              input logic err, input int inc);
    vec_t v;
    v.n = n; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.sop = sop; v.eop = eop;
    v.commit = commit; v.id = id; v.data = data; v.err = err; v.inc = inc;
    return v;
  endfunction

  // Every upd_o pulse must match the oldest expected commit.
  always @(negedge clk_i) begin
    if (upd_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: id=%0d data=%h, expected no update", upd_id_o, upd_data_o);
      end else begin
        exp_u = sb.pop_front();
        if (upd_id_o !== exp_u.id || upd_data_o !== exp_u.data) begin
          errors++;
          $display("FAIL upd: id=%0d data=%h, expected id=%0d data=%h", upd_id_o, upd_data_o, exp_u.id, exp_u.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) m_bank[i] = '0;
    vt[0] = mk(2, 32'h02001000, 32'h00001A80, 0, 3'b001, 3'b010, 1, 2, 32'h00001A80, 0, 0);
    vt[1] = mk(1, 32'h03000101, 0, 0, 3'b001, 3'b001, 1, 3, 32'h0, 1, 0);
    vt[2] = mk(2, 32'h04002000, 32'h11111111, 0, 3'b001, 3'b010, 0, 4, 0, 0, 1);
    vt[3] = mk(2, 32'h05001000, 32'h0000BEEF, 0, 3'b001, 3'b010, 1, 5, 32'h0000BEEF, 0, 0);
    vt[4] = mk(1, 32'h12345678, 0, 0, 3'b000, 3'b001, 0, 0, 0, 0, 1);
    vt[5] = mk(3, 32'h07001000, 32'hAAAA0001, 32'hBBBB0002, 3'b001, 3'b100, 0, 7, 0, 0, 1);
    vt[6] = mk(1, 32'h08000000, 0, 0, 3'b001, 3'b001, 0, 8, 0, 0, 1);
    vt[7] = mk(3, 32'h09002000, 32'hCAFE0009, 32'h0000FFFF, 3'b001, 3'b100, 1, 9, 32'hCAFE0009, 0, 0);
    vt[8] = mk(3, 32'h0A002000, 32'h0B001000, 32'h00000123, 3'b011, 3'b100, 1, 11, 32'h00000123, 0, 1);
    vt[9] = mk(1, 32'h0C001005, 0, 0, 3'b001, 3'b001, 0, 12, 0, 0, 1);

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {31'd0, rsp_ready_o}, 0);
    chk("rst_upd", {31'd0, upd_o}, 0);
    chk("rst_cnt", {24'd0, proto_err_cnt_o}, 0);
    chk("rst_valid", {16'd0, slot_valid_o}, 0);
    chk("rst_rd", rd_data_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", {31'd0, rsp_ready_o}, 1);

    for (int v = 0; v < 10; v++) begin
      for (int b = 0; b < vt[v].n; b++) begin
        if (b == vt[v].n - 1 && vt[v].commit) push(vt[v].id, vt[v].data);
        beat(vt[v].d[b], vt[v].sop[b], vt[v].eop[b]);
      end
      idle(2);
      if (vt[v].commit) begin
        m_bank[vt[v].id] = vt[v].data;
        m_valid[vt[v].id] = 1'b1;
        m_err[vt[v].id] = vt[v].err;
      end
      m_cnt += vt[v].inc;
      chk($sformatf("vec%0d_cnt", v), {24'd0, proto_err_cnt_o}, m_cnt);
      chk($sformatf("vec%0d_valid", v), {16'd0, slot_valid_o}, {16'd0, m_valid});
      chk($sformatf("vec%0d_err", v), {16'd0, slot_err_o}, {16'd0, m_err});
      rd_addr_i = vt[v].id;
      @(negedge clk_i);
      chk($sformatf("vec%0d_rd", v), rd_data_o, m_bank[vt[v].id]);
    end

    // Back-to-back packets, no gap
    beat(32'h0D001000, 1, 0); push(13, 32'h0000D00D);
    beat(32'h0000D00D, 0, 1);
    beat(32'h0E001000, 1, 0); push(14, 32'h0000E00E);
    beat(32'h0000E00E, 0, 1);
    idle(2);
    m_valid[13] = 1'b1; m_valid[14] = 1'b1;
    chk("b2b_valid", {16'd0, slot_valid_o}, {16'd0, m_valid});

    // Read on the commit edge returns the old word
    rd_addr_i = 4'd2;
    beat(32'h02001000, 1, 0); push(2, 32'h00005555);
    beat(32'h00005555, 0, 1);
    chk("rd_old", rd_data_o, 32'h00001A80);
    idle(1);
    chk("rd_new", rd_data_o, 32'h00005555);

    // Clear coinciding with the commit of ID 6
    beat(32'h06001000, 1, 0); push(6, 32'h00006666);
    clear_i = 1'b1;
    beat(32'h00006666, 0, 1);
    clear_i = 1'b0;
    idle(2);
    chk("clr_commit_valid", {16'd0, slot_valid_o}, 32'h0040);
    chk("clr_commit_err", {16'd0, slot_err_o}, 0);

    // Error counter saturation; clear leaves it alone
    for (int i = 0; i < 300; i++) beat(i, 0, 1);
    idle(1);
    chk("cnt_sat", {24'd0, proto_err_cnt_o}, 255);
    clear_i = 1'b1; idle(1); clear_i = 1'b0; idle(1);
    chk("clr_keeps_cnt", {24'd0, proto_err_cnt_o}, 255);
    chk("clr_valid", {16'd0, slot_valid_o}, 0);

    // Reset in the middle of a DATA phase
    beat(32'h02002000, 1, 0);
    beat(32'h00000077, 0, 0);
    rst_i = 1'b1;
    idle(1);
    chk("mid_rst_ready", {31'd0, rsp_ready_o}, 0);
    chk("mid_rst_cnt", {24'd0, proto_err_cnt_o}, 0);
    chk("mid_rst_valid", {16'd0, slot_valid_o}, 0);
    chk("mid_rst_upd", {31'd0, upd_o}, 0);
    rst_i = 1'b0;
    rd_addr_i = 4'd2;
    idle(1);
    chk("mid_rst_bank", rd_data_o, 0);
    beat(32'h00000099, 0, 1);
    idle(2);
    chk("post_rst_orphan", {24'd0, proto_err_cnt_o}, 1);
    beat(32'h02001000, 1, 0); push(2, 32'h00002222);
    beat(32'h00002222, 0, 1);
    idle(2);
    chk("post_rst_valid", {16'd0, slot_valid_o}, 32'h0004);
    chk("post_rst_rd", rd_data_o, 32'h00002222);

`ifdef DOC_RSP_TIMEOUT_EN
    begin
      int waited = 0;
      bit seen = 0;
      beat(32'h05001000, 1, 0);
      rsp_valid_i = 1'b0; rsp_sop_i = 1'b0; rsp_eop_i = 1'b0;
      while (!seen && waited < 1100) begin
        @(negedge clk_i);
        waited++;
        seen = timeout_o;
      end
      chk("timeout_seen", {31'd0, seen}, 1);
      idle(1);
      chk("timeout_pulse", {31'd0, timeout_o}, 0);
      chk("timeout_cnt", {24'd0, proto_err_cnt_o}, 2);
      beat(32'h05001000, 1, 0); push(5, 32'h0000ABCD);
      beat(32'h0000ABCD, 0, 1);
      idle(2);
      chk("timeout_next_valid", {16'd0, slot_valid_o}, 32'h0024);
    end
`endif

    idle(2);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
